// File: rtl/layer_sequencer_pkg.sv
// Shared definitions for the per-frame layer sequencer: FSM state encoding
// and the fixed drawing-layer index assignments.
package layer_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LRST,
        ST_DRAW,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int LAYER_BG    = 0;
    localparam int LAYER_BOARD = 1;
    localparam int LAYER_BALL  = 2;

endpackage

// File: rtl/layer_sequencer_valid_delay_line.sv
// Enable-gated shift register that delays the VRAM write strobe so it lines
// up with the drawing layer's pipelined screen address.
module valid_delay_line #(
    parameter int DEPTH = 2
) (
    input  logic CLK,
    input  logic rst,
    input  logic ena,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] stages;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge CLK) begin
                if (rst) stages <= '0;
                else if (ena) stages <= din;
            end
        end else begin : g_multi
            // NOTE: sequential state uses <= so every stage samples its
            // predecessor's pre-edge value; blocking would collapse the chain.
            always_ff @(posedge CLK) begin
                if (rst) stages <= '0;
                else if (ena) stages <= {stages[DEPTH-2:0], din};
            end
        end
    endgenerate

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/layer_sequencer.sv
// Walks the enabled drawing layers once per frame (reset, draw, drain),
// aligns VRAM write enables with the layer pipeline and flips the frame buffer.
module layer_sequencer
    import layer_sequencer_pkg::*;
#(
    parameter int NUM_LAYERS = 3,
    parameter int IDX_W      = 2,
    parameter int PIPE_DEPTH = 2
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  frame_start,
    input  logic [NUM_LAYERS-1:0] i_layer_en,
    input  logic [NUM_LAYERS-1:0] i_layerend,
    output logic                  o_layer_rst,
    output logic [NUM_LAYERS-1:0] o_cur_state,
    output logic [IDX_W-1:0]      o_layer_idx,
    output logic                  o_vram_we,
    output logic                  o_busy,
    output logic                  o_frame_done,
    output logic                  o_buf_sel,
    output logic                  o_overrun
);

    localparam int CNT_W = (PIPE_DEPTH > 2) ? $clog2(PIPE_DEPTH) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(PIPE_DEPTH > 1 ? PIPE_DEPTH - 2 : 0);

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic [NUM_LAYERS-1:0]   mask;
    logic [CNT_W-1:0]        drain_cnt;
    logic                    buf_sel;

    logic [NUM_LAYERS-1:0]   sel_vec;
    logic                    layerend_cur;
    logic [IDX_W:0]          first_hit;
    logic [IDX_W:0]          next_hit;
    state_t                  exit_state;
    logic [IDX_W-1:0]        exit_idx;
    logic                    we_in;
    logic                    we_out;

    // Lowest enabled layer at or above start; MSB of the result flags a hit.
    function automatic logic [IDX_W:0] find_layer(input logic [NUM_LAYERS-1:0] m, input int start);
        logic [IDX_W:0] r;
        r = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (m[i] && i >= start) r = {1'b1, IDX_W'(i)};
        end
        return r;
    endfunction

    assign sel_vec      = NUM_LAYERS'(1) << idx;
    assign layerend_cur = |(i_layerend & sel_vec);
    assign first_hit    = find_layer(i_layer_en, 0);
    assign next_hit     = find_layer(mask, int'(idx) + 1);
    assign exit_state   = next_hit[IDX_W] ? ST_LRST : ST_DONE;
    assign exit_idx     = next_hit[IDX_W] ? next_hit[IDX_W-1:0] : idx;

    always_ff @(posedge CLK) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            mask      <= '0;
            drain_cnt <= '0;
            buf_sel   <= 1'b0;
        end else if (ena) begin
            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        mask <= i_layer_en;
                        if (first_hit[IDX_W]) begin
                            idx   <= first_hit[IDX_W-1:0];
                            state <= ST_LRST;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_LRST: begin
                    drain_cnt <= '0;
                    state     <= ST_DRAW;
                end
                ST_DRAW: begin
                    if (layerend_cur) begin
                        if (PIPE_DEPTH > 1) begin
                            state <= ST_DRAIN;
                        end else begin
                            idx   <= exit_idx;
                            state <= exit_state;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        idx   <= exit_idx;
                        state <= exit_state;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    buf_sel <= ~buf_sel;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Pixels are written only while the layer has not yet reached its end.
    assign we_in = (state == ST_DRAW) && !layerend_cur;

    valid_delay_line #(
        .DEPTH (PIPE_DEPTH)
    ) u_we_pipe (
        .CLK  (CLK),
        .rst  (rst),
        .ena  (ena),
        .din  (we_in),
        .dout (we_out)
    );

    assign o_vram_we    = ena && we_out;
    assign o_layer_rst  = (state == ST_LRST);
    assign o_cur_state  = (state inside {ST_LRST, ST_DRAW, ST_DRAIN}) ? sel_vec : '0;
    assign o_layer_idx  = idx;
    assign o_busy       = (state != ST_IDLE);
    assign o_frame_done = ena && (state == ST_DONE);
    assign o_buf_sel    = buf_sel;
    assign o_overrun    = ena && frame_start && (state != ST_IDLE);

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: three 4x2-pixel layer models feed
// end-of-layer flags back, and each scenario checks timing and write counts.
module tb_layer_sequencer;
    import layer_sequencer_pkg::*;

    logic       CLK = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic       frame_start = 1'b0;
    logic [2:0] i_layer_en = 3'b000;
    logic [2:0] i_layerend;
    logic       o_layer_rst;
    logic [2:0] o_cur_state;
    logic [1:0] o_layer_idx;
    logic       o_vram_we;
    logic       o_busy;
    logic       o_frame_done;
    logic       o_buf_sel;
    logic       o_overrun;

    int n_checks = 0;
    int n_errors = 0;

    // Statistics gathered by the monitor.
    int cyc = 0;
    int wr_total, we_while_off, n_lrst, n_done, n_overrun, overrun_cyc;
    int wr_layer [4];
    int lrst_cyc [4];
    int lrst_idx [4];
    logic sel1_seen;
    logic [1:0] idx_at_rst;
    logic [2:0] sel_at_rst;

    logic [3:0] pix_cnt [3];

    layer_sequencer #(
        .NUM_LAYERS (3),
        .IDX_W      (2),
        .PIPE_DEPTH (2)
    ) dut (
        .CLK          (CLK),
        .rst          (rst),
        .ena          (ena),
        .frame_start  (frame_start),
        .i_layer_en   (i_layer_en),
        .i_layerend   (i_layerend),
        .o_layer_rst  (o_layer_rst),
        .o_cur_state  (o_cur_state),
        .o_layer_idx  (o_layer_idx),
        .o_vram_we    (o_vram_we),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done),
        .o_buf_sel    (o_buf_sel),
        .o_overrun    (o_overrun)
    );

    always #5 CLK = ~CLK;

    // Drawing layer model: 8-pixel counter, cleared by the broadcast reset,
    // advances while selected, saturates at the end-of-layer value.
    always @(posedge CLK) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) pix_cnt[i] <= 4'd0;
            else if (ena) begin
                if (o_layer_rst) pix_cnt[i] <= 4'd0;
                else if (o_cur_state[i] && pix_cnt[i] != 4'd8) pix_cnt[i] <= pix_cnt[i] + 4'd1;
            end
        end
    end

    assign i_layerend = {pix_cnt[2] == 4'd8, pix_cnt[1] == 4'd8, pix_cnt[0] == 4'd8};

    always @(negedge CLK) begin
        if (o_vram_we) begin
            wr_total++;
            wr_layer[o_layer_idx]++;
        end
        if (!ena && o_vram_we) we_while_off++;
        if (o_layer_rst && ena) begin
            if (n_lrst < 4) begin
                lrst_cyc[n_lrst] = cyc;
                lrst_idx[n_lrst] = int'(o_layer_idx);
            end
            n_lrst++;
        end
        if (o_frame_done) n_done++;
        if (o_overrun) begin
            n_overrun++;
            overrun_cyc = cyc;
        end
        if (o_cur_state[1]) sel1_seen = 1'b1;
    end

    task automatic clear_stats();
        wr_total = 0; we_while_off = 0; n_lrst = 0; n_done = 0;
        n_overrun = 0; overrun_cyc = 0; sel1_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_layer[i] = 0; lrst_cyc[i] = 0; lrst_idx[i] = -1;
        end
    endtask

    // Launch one frame and return the accept-to-done latency in cycles
    // (-1 on timeout or when the frame is cut short by rst_at).
    task automatic run_frame(input logic [2:0] mask, input int pause_at, input int pause_len,
                             input int overrun_at, input int rst_at, output int cycles);
        cycles = -1;
        @(posedge CLK); #1;
        i_layer_en  = mask;
        frame_start = 1'b1;
        @(posedge CLK); #1;
        frame_start = 1'b0;
        i_layer_en  = ~mask;
        for (int n = 1; n <= 200; n++) begin
            cyc = n;
            if (rst_at != 0 && n == rst_at + 1) begin
                rst = 1'b0;
                return;
            end
            ena         = !(pause_at != 0 && n >= pause_at && n < pause_at + pause_len);
            frame_start = (n == overrun_at);
            rst         = (n == rst_at);
            @(negedge CLK);
            if (n == rst_at) begin
                idx_at_rst = o_layer_idx;
                sel_at_rst = o_cur_state;
            end
            if (o_frame_done) begin
                cycles = n;
                break;
            end
            @(posedge CLK); #1;
        end
        ena         = 1'b1;
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge CLK);
        #1 rst = 1'b0;
        @(negedge CLK);
        if ({o_busy, o_layer_rst, o_vram_we, o_frame_done, o_overrun} !== 5'b0) begin
            $display("FAIL reset_flags: got %b, expected 00000", {o_busy, o_layer_rst, o_vram_we, o_frame_done, o_overrun});
            n_errors++;
        end
        n_checks++;
        if (o_cur_state !== 3'b000) begin
            $display("FAIL reset_cur_state: got %b, expected 000", o_cur_state);
            n_errors++;
        end
        n_checks++;
        if (o_layer_idx !== 2'd0) begin
            $display("FAIL reset_idx: got %0d, expected 0", o_layer_idx);
            n_errors++;
        end
        n_checks++;
        if (o_buf_sel !== 1'b0) begin
            $display("FAIL reset_buf_sel: got %b, expected 0", o_buf_sel);
            n_errors++;
        end
        n_checks++;
    endtask

    task automatic test_full_frame();
        int cycles;
        clear_stats();
        run_frame(3'b111, 0, 0, 0, 0, cycles);
        if (cycles !== 34) begin
            $display("FAIL full_latency: got %0d, expected 34", cycles);
            n_errors++;
        end
        n_checks++;
        if (wr_total !== 24) begin
            $display("FAIL full_writes: got %0d, expected 24", wr_total);
            n_errors++;
        end
        n_checks++;
        for (int i = 0; i < 3; i++) begin
            if (wr_layer[i] !== 8) begin
                $display("FAIL full_writes_layer%0d: got %0d, expected 8", i, wr_layer[i]);
                n_errors++;
            end
            n_checks++;
        end
        if (n_lrst !== 3 || lrst_cyc[1] - lrst_cyc[0] !== 11 || lrst_cyc[2] - lrst_cyc[1] !== 11) begin
            $display("FAIL full_layer_period: got %0d resets at %0d/%0d/%0d, expected 3 at 1/12/23",
                     n_lrst, lrst_cyc[0], lrst_cyc[1], lrst_cyc[2]);
            n_errors++;
        end
        n_checks++;
        if (o_buf_sel !== 1'b0) begin
            $display("FAIL full_buf_during_done: got %b, expected 0", o_buf_sel);
            n_errors++;
        end
        n_checks++;
        @(negedge CLK);
        if (o_buf_sel !== 1'b1 || o_busy !== 1'b0) begin
            $display("FAIL full_buf_after: got buf=%b busy=%b, expected buf=1 busy=0", o_buf_sel, o_busy);
            n_errors++;
        end
        n_checks++;
    endtask

    task automatic test_mask_101();
        int cycles;
        clear_stats();
        run_frame(3'b101, 0, 0, 0, 0, cycles);
        if (cycles !== 23) begin
            $display("FAIL m101_latency: got %0d, expected 23", cycles);
            n_errors++;
        end
        n_checks++;
        if (wr_total !== 16 || wr_layer[LAYER_BOARD] !== 0) begin
            $display("FAIL m101_writes: got total=%0d layer1=%0d, expected 16 and 0", wr_total, wr_layer[LAYER_BOARD]);
            n_errors++;
        end
        n_checks++;
        if (sel1_seen !== 1'b0) begin
            $display("FAIL m101_layer1_selected: got %b, expected 0", sel1_seen);
            n_errors++;
        end
        n_checks++;
        if (n_lrst !== 2 || lrst_idx[0] !== LAYER_BG || lrst_idx[1] !== LAYER_BALL) begin
            $display("FAIL m101_idx_order: got %0d resets idx %0d,%0d, expected 2 resets idx 0,2",
                     n_lrst, lrst_idx[0], lrst_idx[1]);
            n_errors++;
        end
        n_checks++;
        @(negedge CLK);
        if (o_buf_sel !== 1'b0) begin
            $display("FAIL m101_buf: got %b, expected 0", o_buf_sel);
            n_errors++;
        end
        n_checks++;
    endtask

    task automatic test_mask_zero();
        int cycles;
        clear_stats();
        run_frame(3'b000, 0, 0, 0, 0, cycles);
        if (cycles !== 1) begin
            $display("FAIL m000_latency: got %0d, expected 1", cycles);
            n_errors++;
        end
        n_checks++;
        if (n_lrst !== 0 || wr_total !== 0) begin
            $display("FAIL m000_activity: got resets=%0d writes=%0d, expected 0 and 0", n_lrst, wr_total);
            n_errors++;
        end
        n_checks++;
        @(negedge CLK);
        if (o_buf_sel !== 1'b1) begin
            $display("FAIL m000_buf: got %b, expected 1", o_buf_sel);
            n_errors++;
        end
        n_checks++;
    endtask

    task automatic test_ena_pause();
        int cycles;
        clear_stats();
        run_frame(3'b111, 5, 5, 0, 0, cycles);
        if (cycles !== 39) begin
            $display("FAIL pause_latency: got %0d, expected 39", cycles);
            n_errors++;
        end
        n_checks++;
        if (wr_total !== 24) begin
            $display("FAIL pause_writes: got %0d, expected 24", wr_total);
            n_errors++;
        end
        n_checks++;
        if (we_while_off !== 0) begin
            $display("FAIL pause_we_while_off: got %0d, expected 0", we_while_off);
            n_errors++;
        end
        n_checks++;
        @(negedge CLK);
        if (o_buf_sel !== 1'b0) begin
            $display("FAIL pause_buf: got %b, expected 0", o_buf_sel);
            n_errors++;
        end
        n_checks++;
    endtask

    task automatic test_overrun();
        int cycles;
        clear_stats();
        run_frame(3'b111, 0, 0, 6, 0, cycles);
        if (n_overrun !== 1 || overrun_cyc !== 6) begin
            $display("FAIL overrun_pulse: got %0d pulses at cycle %0d, expected 1 at cycle 6", n_overrun, overrun_cyc);
            n_errors++;
        end
        n_checks++;
        if (cycles !== 34 || wr_total !== 24) begin
            $display("FAIL overrun_frame: got latency=%0d writes=%0d, expected 34 and 24", cycles, wr_total);
            n_errors++;
        end
        n_checks++;
        repeat (4) @(negedge CLK);
        if (n_done !== 1 || o_busy !== 1'b0) begin
            $display("FAIL overrun_single_done: got done=%0d busy=%b, expected 1 and 0", n_done, o_busy);
            n_errors++;
        end
        n_checks++;
        if (o_buf_sel !== 1'b1) begin
            $display("FAIL overrun_buf: got %b, expected 1", o_buf_sel);
            n_errors++;
        end
        n_checks++;
    endtask

    task automatic test_reset_mid_frame();
        int cycles;
        clear_stats();
        run_frame(3'b111, 0, 0, 0, 16, cycles);
        if (idx_at_rst !== 2'd1 || sel_at_rst !== 3'b010) begin
            $display("FAIL midrst_position: got idx=%0d sel=%b, expected idx=1 sel=010", idx_at_rst, sel_at_rst);
            n_errors++;
        end
        n_checks++;
        @(negedge CLK);
        if ({o_busy, o_layer_rst, o_vram_we, o_frame_done, o_overrun, o_buf_sel} !== 6'b0 ||
            o_cur_state !== 3'b000 || o_layer_idx !== 2'd0) begin
            $display("FAIL midrst_outputs: got flags=%b sel=%b idx=%0d, expected all zero",
                     {o_busy, o_layer_rst, o_vram_we, o_frame_done, o_overrun, o_buf_sel}, o_cur_state, o_layer_idx);
            n_errors++;
        end
        n_checks++;
        clear_stats();
        repeat (5) @(negedge CLK);
        if (wr_total !== 0 || o_busy !== 1'b0) begin
            $display("FAIL midrst_quiet: got writes=%0d busy=%b, expected 0 and 0", wr_total, o_busy);
            n_errors++;
        end
        n_checks++;
        clear_stats();
        run_frame(3'b111, 0, 0, 0, 0, cycles);
        if (cycles !== 34 || wr_total !== 24 || lrst_idx[0] !== LAYER_BG) begin
            $display("FAIL midrst_restart: got latency=%0d writes=%0d first_idx=%0d, expected 34, 24, 0",
                     cycles, wr_total, lrst_idx[0]);
            n_errors++;
        end
        n_checks++;
        @(negedge CLK);
        if (o_buf_sel !== 1'b1) begin
            $display("FAIL midrst_buf: got %b, expected 1", o_buf_sel);
            n_errors++;
        end
        n_checks++;
    endtask

    initial begin
        clear_stats();
        test_reset();
        test_full_frame();
        test_mask_101();
        test_mask_zero();
        test_ena_pause();
        test_overrun();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
